// File: rtl/cv32e40p_wb_queue.sv
// cv32e40p_wb_queue: round-robin arbitrated FIFO collecting results from several sources for one register write port
module cv32e40p_wb_queue #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int CSTM_W  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                src_valid_i,
  output logic [NUM_SRC-1:0]                src_ready_o,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]    src_waddr_i,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]    src_wdata_i,
  input  logic [NUM_SRC-1:0][CSTM_W-1:0]    src_cstm_i,
  input  logic                              flush_i,
  output logic                              wb_we_o,
  output logic [ADDR_W-1:0]                 wb_waddr_o,
  output logic [DATA_W-1:0]                 wb_wdata_o,
  output logic [CSTM_W-1:0]                 wb_cstm_o,
  input  logic                              wb_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]        count_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic                              contention_o
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_W-1:0] r_mem_a [DEPTH];
  logic [DATA_W-1:0] r_mem_d [DEPTH];
  logic [CSTM_W-1:0] r_mem_c [DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_rr;
  logic [SW-1:0]     w_idx;
  logic              w_any, w_push, w_pop;
  // first valid source found when searching upward from r_rr (lowest offset wins)
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      if (src_valid_i[SW'((int'(r_rr) + k) % NUM_SRC)]) begin
        w_any = 1'b1;
        w_idx = SW'((int'(r_rr) + k) % NUM_SRC);
      end
    end
  end
  assign empty_o      = r_cnt == '0;
  assign full_o       = r_cnt == CW'(DEPTH);
  assign count_o      = r_cnt;
  assign wb_we_o      = !empty_o;
  assign w_pop        = wb_we_o & wb_ready_i;
  assign w_push       = w_any & (!full_o | w_pop) & !flush_i & !rst_n;
  assign src_ready_o  = w_push ? (NUM_SRC'(1) << w_idx) : '0;
  assign contention_o = $countones(src_valid_i) > 1;
  assign wb_waddr_o   = wb_we_o ? r_mem_a[r_rp] : '0;
  assign wb_wdata_o   = wb_we_o ? r_mem_d[r_rp] : '0;
  assign wb_cstm_o    = wb_we_o ? r_mem_c[r_rp] : '0;
  // storage is never read while empty, so it is left unreset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wp] <= src_waddr_i[w_idx];
      r_mem_d[r_wp] <= src_wdata_i[w_idx];
      r_mem_c[r_wp] <= src_cstm_i[w_idx];
    end
  end
  // pointers, occupancy and arbitration priority; flush drops everything but keeps priority
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_rr  <= '0;
    end else if (flush_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_push) r_rr <= (int'(w_idx) == NUM_SRC-1) ? '0 : w_idx + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: doc/cv32e40p_wb_queue.md
CV32E40P_WB_QUEUE -- requirements
Module: cv32e40p_wb_queue

Interface
REQ-001 Parameter NUM_SRC, default 2, is the number of result sources; legal range 2..4.
REQ-002 Parameter DEPTH, default 2, is the number of queue entries; it SHALL be a power of two in the range 2..8.
REQ-003 Parameter ADDR_W, default 6, is the register write-address width.
REQ-004 Parameter DATA_W, default 32, is the write-data width.
REQ-005 Parameter CSTM_W, default 32, is the width of the custom countermeasure sideband.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-high reset; state is cleared while rst_n=1. The name is kept for codebase consistency.
REQ-008 src_valid_i  in  NUM_SRC  per-source result valid.
REQ-009 src_ready_o  out  NUM_SRC  per-source accept (grant AND space).
REQ-010 src_waddr_i  in  NUM_SRC x ADDR_W  per-source destination register.
REQ-011 src_wdata_i  in  NUM_SRC x DATA_W  per-source result data.
REQ-012 src_cstm_i  in  NUM_SRC x CSTM_W  per-source countermeasure sideband.
REQ-013 flush_i  in  1  synchronous queue flush.
REQ-014 wb_we_o  out  1  head entry valid, i.e. write-port request.
REQ-015 wb_waddr_o  out  ADDR_W  head destination.
REQ-016 wb_wdata_o  out  DATA_W  head data.
REQ-017 wb_cstm_o  out  CSTM_W  head sideband.
REQ-018 wb_ready_i  in  1  write port consumes head this cycle.
REQ-019 count_o  out  clog2(DEPTH+1)  occupied entries.
REQ-020 full_o / empty_o  out  1 each  count_o==DEPTH / count_o==0.
REQ-021 contention_o  out  1  more than one src_valid_i high this cycle (combinational).

Function
REQ-022 Push and pop definitions:
- pop = wb_we_o & wb_ready_i.
- push = any src_ready_o high.
REQ-023 At most one source SHALL be granted per cycle, by round-robin search starting at rr_q.
REQ-024 A grant SHALL be issued only if (!full_o | pop) & !flush_i.
- src_ready_o[i]=1 only for the granted i.
- All other src_ready_o bits SHALL be 0.
REQ-025 rr_q SHALL update to (granted index + 1) mod NUM_SRC on push; otherwise it holds.
REQ-026 A pushed entry SHALL appear on wb_* no earlier than the next cycle; there is no combinational bypass from src_* to wb_*.
REQ-027 Entries SHALL be output in FIFO order.
- Write and read pointers wrap modulo DEPTH.
- Simultaneous push and pop at full leaves count_o unchanged.
- Simultaneous push and pop at empty is impossible, because pop requires wb_we_o.
REQ-028 Head presentation:
- wb_we_o = !empty_o.
- When empty, wb_waddr_o, wb_wdata_o and wb_cstm_o SHALL be 0.
REQ-029 Head outputs SHALL be driven from registers only; there is no combinational path from wb_ready_i or src_* to wb_*.
REQ-030 flush_i=1 SHALL have the following effect at the next edge:
- count, read pointer and write pointer are set to 0.
- Pending pop and push that cycle are discarded.
- rr_q holds.
REQ-031 count_o SHALL equal pushes minus pops since the last reset or flush, saturating by construction at DEPTH.
REQ-032 contention_o SHALL be informational only and SHALL NOT affect the grant.

Reset
REQ-033 With rst_n=1, asynchronously:
- count, pointers and rr_q are 0.
- wb_we_o=0, wb_* data=0, empty_o=1, full_o=0, src_ready_o=0.
REQ-034 Reset asserted mid-transfer SHALL discard all entries; the first cycle after deassertion behaves as an empty queue with rr_q=0.
REQ-035 Storage arrays need not be reset, but no unreset value SHALL be visible on wb_* while empty.

Verification
REQ-036 Single push: src 0 offers valid waddr=5, wdata=0xDEADBEEF, cstm=0x1, with wb_ready_i=0.
- Cycle 0: src_ready_o=01.
- Cycle 1: wb_we_o=1, wb_waddr_o=5, wb_wdata_o=0xDEADBEEF, count_o=1.
REQ-037 Round-robin: NUM_SRC=2, both sources valid continuously, wb_ready_i=1.
- Grants alternate 0,1,0,1.
- contention_o=1 every cycle.
- wb_wdata_o order matches the grant order.
REQ-038 Full back-pressure: DEPTH=2, wb_ready_i=0, three pushes offered.
- The third sees src_ready_o=0 and full_o=1.
- Raising wb_ready_i then grants the third in the same cycle; count_o stays 2.
REQ-039 Flush: with 2 entries queued, flush_i=1 together with a valid source and wb_ready_i=1.
- Next cycle: count_o=0, wb_we_o=0, wb_* data=0.
- src_ready_o was 0 during the flush cycle.
REQ-040 Async reset mid-stream: assert rst_n=1 between clock edges with 1 entry queued.
- Outputs go to reset values immediately.
- After deassertion, the first grant with both sources valid goes to src 0.
REQ-041 Pointer wrap: DEPTH=4, run 10 push/pop pairs with distinct data.
- Output sequence equals input sequence.
- count_o never exceeds 4.
